// File: rtl/main_apb_arb_if.sv
// main_apb_arb_if: one APB3 port.
// master drives the request side, slave drives the response side.
interface main_apb_arb_if #(
  parameter int P_AW = 32,
  parameter int P_DW = 32
);
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [P_AW-1:0] paddr;
  logic [P_DW-1:0] pwdata;
  logic [P_DW-1:0] prdata;
  logic            pready;
  logic            pslverr;

  modport master (
    output psel, penable, pwrite,
    output paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite,
    input  paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/main_apb_arb.sv
// main_apb_arb: two-master round-robin APB3 arbiter.
// Re-issues each grant downstream with an access-phase timeout.
module main_apb_arb #(
  parameter int P_AW      = 32,
  parameter int P_DW      = 32,
  parameter int P_TO_W    = 8,
  parameter int P_TIMEOUT = 255
) (
  input  logic           i_clk_main_apb_arb,
  input  logic           i_rstn_main_apb_arb,
  main_apb_arb_if.slave  m0,
  main_apb_arb_if.slave  m1,
  main_apb_arb_if.master s,
  output logic           o_arb_busy,
  output logic           o_arb_owner,
  output logic           o_timeout_pulse
);
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic [P_TO_W-1:0] TO_LAST =
    P_TO_W'(P_TIMEOUT - 1);
  localparam bit TO_EN = (P_TIMEOUT != 0);

  state_t            state_q;
  state_t            state_d;
  logic              last_q;
  logic              owner_q;
  logic              to_q;
  logic [P_TO_W-1:0] cnt_q;
  logic [P_AW-1:0]   addr_q;
  logic              wr_q;
  logic [P_DW-1:0]   wdata_q;
  logic [P_DW-1:0]   rdata0_q;
  logic [P_DW-1:0]   rdata1_q;
  logic              err0_q;
  logic              err1_q;
  logic              req;
  logic              win;
  logic              to_hit;

  assign req = m0.psel | m1.psel;

  // Abort on the last allowed access cycle with no pready.
  assign to_hit = TO_EN
               && (state_q == ACCESS)
               && !s.pready
               && (cnt_q == TO_LAST);

  // Round-robin pick: on a tie the master not served last wins.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      m0.psel & m1.psel:  win = ~last_q;
      m1.psel & ~m0.psel: win = 1'b1;
      default:            win = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk_main_apb_arb) begin
    if (!i_rstn_main_apb_arb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (s.pready || to_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant capture, access counter and response capture.
  always_ff @(posedge i_clk_main_apb_arb) begin
    if (!i_rstn_main_apb_arb) begin
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      to_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            owner_q <= win;
            last_q  <= win;
            to_q    <= 1'b0;
            addr_q  <= win ? m1.paddr : m0.paddr;
            wr_q    <= win ? m1.pwrite : m0.pwrite;
            wdata_q <= win ? m1.pwdata : m0.pwdata;
          end
        end
        SETUP: cnt_q <= '0;
        ACCESS: begin
          if (s.pready) begin
            if (owner_q) begin
              rdata1_q <= s.prdata;
              err1_q   <= s.pslverr;
            end else begin
              rdata0_q <= s.prdata;
              err0_q   <= s.pslverr;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (to_hit) begin
              to_q <= 1'b1;
              if (owner_q) begin
                rdata1_q <= '0;
                err1_q   <= 1'b1;
              end else begin
                rdata0_q <= '0;
                err0_q   <= 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    s.psel          = (state_q == SETUP)
                   || (state_q == ACCESS);
    s.penable       = (state_q == ACCESS);
    s.pwrite        = wr_q;
    s.paddr         = addr_q;
    s.pwdata        = wdata_q;
    m0.pready       = (state_q == DONE) && !owner_q;
    m1.pready       = (state_q == DONE) && owner_q;
    m0.prdata       = rdata0_q;
    m1.prdata       = rdata1_q;
    m0.pslverr      = err0_q;
    m1.pslverr      = err1_q;
    o_arb_busy      = (state_q != IDLE);
    o_arb_owner     = owner_q;
    o_timeout_pulse = (state_q == DONE) && to_q;
  end
endmodule
